// File: rtl/debug_unit_pkg.sv
// Shared types and frame geometry for the host-side debug controller.
// DBG_CYCLE_COUNT_EN adds a leading cycle-count word to every dump frame.
package debug_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_BYTES,
        LOAD_WRITE,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_CAPTURE,
        DUMP_SEND
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam int IF_ID_WORDS  = 2;
    localparam int ID_EX_WORDS  = 5;
    localparam int EX_MEM_WORDS = 3;
    localparam int MEM_WB_WORDS = 3;
    localparam int LATCH_WORDS  = IF_ID_WORDS + ID_EX_WORDS + EX_MEM_WORDS + MEM_WB_WORDS;
    localparam int REG_WORDS    = 32;

`ifdef DBG_CYCLE_COUNT_EN
    localparam int CNT_WORDS = 1;
`else
    localparam int CNT_WORDS = 0;
`endif

    function automatic int frame_words(input int mem_dump_words);
        return CNT_WORDS + LATCH_WORDS + REG_WORDS + mem_dump_words;
    endfunction

endpackage

// File: rtl/debug_unit_if.sv
// UART byte streams and instruction-memory write port of the debug controller.
interface debug_unit_if;
    import debug_unit_pkg::*;

    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_write_instruction_flag;
    logic [31:0] o_instruction_to_write;
    logic [31:0] o_address_to_write_inst;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready,
        output o_tx_data, o_tx_valid,
        output o_write_instruction_flag, o_instruction_to_write, o_address_to_write_inst
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready,
        input  o_tx_data, o_tx_valid,
        input  o_write_instruction_flag, o_instruction_to_write, o_address_to_write_inst
    );

endinterface

// File: rtl/debug_unit_serializer.sv
// Splits a 32-bit word into 4 bytes, MSB first, over a valid/ready handshake.
module dbg_word_serializer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_word,
    input  logic        i_load,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done
);

    logic [31:0] shreg;
    logic [1:0]  cnt;
    logic        busy;

    assign o_data  = shreg[31:24];
    assign o_valid = busy;
    assign o_busy  = busy;
    // Combinational so the caller can move on in the same cycle as the last handshake.
    assign o_done  = busy && i_ready && (cnt == 2'd3);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (i_load) begin
            shreg <= i_word;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy && i_ready) begin
            shreg <= {shreg[23:0], 8'h00};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Debug controller: loads program words from UART, runs/steps the pipeline, dumps state.
// Define DBG_CYCLE_COUNT_EN to prepend a saturating run-cycle counter to each dump frame.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int          IMEM_WORDS     = 256,
    parameter int          MEM_DUMP_WORDS = 32,
    parameter logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF
) (
    input  logic         i_clk,
    input  logic         i_reset,
    debug_unit_if.master bus,
    output logic         o_halt,
    output logic         o_stall,
    input  logic [63:0]  i_IF_ID_latch,
    input  logic [138:0] i_ID_EX_latch,
    input  logic [75:0]  i_EX_MEM_latch,
    input  logic [70:0]  i_MEM_WB_latch,
    output logic [4:0]   o_reg_read,
    input  logic [31:0]  i_reg_content,
    output logic [31:0]  o_addr_to_read_mem,
    input  logic [31:0]  i_mem_addr_content,
    input  logic         i_program_end
);

    localparam logic [15:0] LAST_WORD = 16'(frame_words(MEM_DUMP_WORDS) - 1);
    localparam logic [15:0] REG_BASE  = 16'(LATCH_WORDS);
    localparam logic [15:0] MEM_BASE  = 16'(LATCH_WORDS + REG_WORDS);
    localparam logic [15:0] MEM_END   = 16'(LATCH_WORDS + REG_WORDS + MEM_DUMP_WORDS);
    localparam logic [31:0] ADDR_LAST = 32'((IMEM_WORDS - 1) * 4);

    state_t      state, state_n;
    logic [31:0] asm_word, asm_word_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] load_addr, load_addr_n;
    logic        ended, ended_n;
    logic [15:0] word_idx, word_idx_n;
    logic        ser_load, ser_busy, ser_done;
    logic        load_done;
    logic [31:0] src_word;

    assign load_done = (state == LOAD_WRITE) && (asm_word == HALT_INSTR);

    assign o_halt  = !(((state == RUN) || (state == STEP)) && !ended);
    assign o_stall = (state == LOAD_BYTES) || (state == LOAD_WRITE);

    assign bus.o_write_instruction_flag = (state == LOAD_WRITE);
    assign bus.o_instruction_to_write   = asm_word;
    assign bus.o_address_to_write_inst  = load_addr;

    // Section-relative index; with the counter enabled word 0 wraps out of every range.
    logic [15:0]  sec;
    logic [3:0]   lat_sel;
    logic [415:0] lat_vec;

    assign sec     = word_idx - 16'(CNT_WORDS);
    assign lat_sel = 4'(LATCH_WORDS - 1) - sec[3:0];
    assign lat_vec = {i_IF_ID_latch, 21'b0, i_ID_EX_latch, 20'b0, i_EX_MEM_latch,
                      25'b0, i_MEM_WB_latch};

    assign o_reg_read = (sec >= REG_BASE && sec < MEM_BASE) ? 5'(sec - REG_BASE) : 5'd0;
    assign o_addr_to_read_mem = (sec >= MEM_BASE && sec < MEM_END) ?
                                {14'b0, sec - MEM_BASE, 2'b00} : 32'd0;

`ifdef DBG_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset || load_done)          cycle_cnt <= '0;
        else if (!o_halt && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    always_comb begin
        src_word = '0;
        if (sec < REG_BASE)      src_word = lat_vec[{lat_sel, 5'b0} +: 32];
        else if (sec < MEM_BASE) src_word = i_reg_content;
        else                     src_word = i_mem_addr_content;
`ifdef DBG_CYCLE_COUNT_EN
        if (word_idx == 16'd0)   src_word = cycle_cnt;
`endif
    end

    dbg_word_serializer u_ser (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_word  (src_word),
        .i_load  (ser_load),
        .o_data  (bus.o_tx_data),
        .o_valid (bus.o_tx_valid),
        .i_ready (bus.i_tx_ready),
        .o_busy  (ser_busy),
        .o_done  (ser_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            asm_word  <= '0;
            byte_cnt  <= '0;
            load_addr <= '0;
            ended     <= 1'b0;
            word_idx  <= '0;
        end else begin
            state     <= state_n;
            asm_word  <= asm_word_n;
            byte_cnt  <= byte_cnt_n;
            load_addr <= load_addr_n;
            ended     <= ended_n;
            word_idx  <= word_idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        asm_word_n  = asm_word;
        byte_cnt_n  = byte_cnt;
        load_addr_n = load_addr;
        ended_n     = ended;
        word_idx_n  = word_idx;
        ser_load    = 1'b0;
        unique case (state)
            IDLE: if (bus.i_rx_valid) begin
                unique case (bus.i_rx_data)
                    CMD_LOAD: begin state_n = LOAD_BYTES; byte_cnt_n = '0; end
                    CMD_CONT: state_n = RUN;
                    CMD_STEP: state_n = STEP;
                    default:  state_n = IDLE;
                endcase
            end
            LOAD_BYTES: if (bus.i_rx_valid) begin
                asm_word_n = {asm_word[23:0], bus.i_rx_data};
                byte_cnt_n = byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) state_n = LOAD_WRITE;
            end
            LOAD_WRITE: begin
                load_addr_n = (load_addr == ADDR_LAST) ? 32'd0 : load_addr + 32'd4;
                state_n     = LOAD_BYTES;
                if (load_done) begin
                    state_n     = IDLE;
                    ended_n     = 1'b0;
                    load_addr_n = '0;
                end
            end
            RUN: begin
                if (ended || i_program_end) begin
                    ended_n    = 1'b1;
                    state_n    = DUMP_ADDR;
                    word_idx_n = '0;
                end
            end
            STEP: begin
                if (i_program_end) ended_n = 1'b1;
                state_n    = DUMP_ADDR;
                word_idx_n = '0;
            end
            DUMP_ADDR: state_n = DUMP_CAPTURE;
            DUMP_CAPTURE: if (!ser_busy) begin
                ser_load = 1'b1;
                state_n  = DUMP_SEND;
            end
            DUMP_SEND: if (ser_done) begin
                if (word_idx == LAST_WORD) begin
                    state_n    = IDLE;
                    word_idx_n = '0;
                end else begin
                    state_n    = DUMP_ADDR;
                    word_idx_n = word_idx + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: load, continuous run, step, backpressure, reset mid-dump.
module tb_debug_unit;
    import debug_unit_pkg::*;

`ifdef DBG_CYCLE_COUNT_EN
    localparam int CNT_ON = 1;
    localparam int FRAME_BYTES = 312;
`else
    localparam int CNT_ON = 0;
    localparam int FRAME_BYTES = 308;
`endif

    localparam logic [31:0] LAT_EXP [13] = '{
        32'h11223344, 32'h55667788,
        32'h000007FF, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4,
        32'h00000ABC, 32'hE1E2E3E4, 32'hF1F2F3F4,
        32'h00000055, 32'h0F0E0D0C, 32'h0B0A0908
    };

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_unit_if bus();

    logic         halt, stall, program_end;
    logic [63:0]  if_id;
    logic [138:0] id_ex;
    logic [75:0]  ex_mem;
    logic [70:0]  mem_wb;
    logic [4:0]   reg_read;
    logic [31:0]  reg_content, mem_addr, mem_content;
    logic         pe_arm = 1'b0;
    logic         bp_en  = 1'b0;
    int           run_cnt = 0;

    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];
    int n_pass = 0, n_total = 0;
    int acc = 0, halt_lo = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    debug_unit dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .bus                (bus.master),
        .o_halt             (halt),
        .o_stall            (stall),
        .i_IF_ID_latch      (if_id),
        .i_ID_EX_latch      (id_ex),
        .i_EX_MEM_latch     (ex_mem),
        .i_MEM_WB_latch     (mem_wb),
        .o_reg_read         (reg_read),
        .i_reg_content      (reg_content),
        .o_addr_to_read_mem (mem_addr),
        .i_mem_addr_content (mem_content),
        .i_program_end      (program_end)
    );

    // Pipeline model: register/memory reads return one cycle after the index.
    always @(posedge clk) begin
        reg_content <= 32'hCAFE_0000 | {27'b0, reg_read};
        mem_content <= 32'hD000_0000 | mem_addr;
        if (!halt) run_cnt <= run_cnt + 1;
    end
    assign program_end = pe_arm && (run_cnt >= 19);

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_tx.push_back(w[31 - 8*b -: 8]);
    endtask

    task automatic push_frame(input logic [31:0] cnt);
        if (CNT_ON != 0) push_word(cnt);
        for (int i = 0; i < 13; i++) push_word(LAT_EXP[i]);
        for (int r = 0; r < 32; r++) push_word(32'hCAFE_0000 + 32'(r));
        for (int m = 0; m < 32; m++) push_word(32'hD000_0000 + 32'(4*m));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_frame(input int a0, input int h0, input int exp_halt);
        for (int i = 0; i < 4000 && exp_tx.size() != 0; i++) @(posedge clk);
        chk(exp_tx.size() == 0, "frame_timeout", 64'(exp_tx.size()), 64'd0);
        exp_tx.delete();
        repeat (2) @(posedge clk);
        #1;
        chk(acc - a0 == FRAME_BYTES, "frame_len", 64'(acc - a0), 64'(FRAME_BYTES));
        chk(halt_lo - h0 == exp_halt, "halt_low_cycles", 64'(halt_lo - h0), 64'(exp_halt));
        chk(!bus.o_tx_valid && dut.state == IDLE, "frame_idle",
            {bus.o_tx_valid, 60'(dut.state)}, 64'd0);
    endtask

    // TX backpressure driver.
    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.i_tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected bytes/writes as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_v && !prev_r)
                chk(bus.o_tx_valid && bus.o_tx_data == prev_d, "tx_hold",
                    {bus.o_tx_valid, 8'(bus.o_tx_data)}, {1'b1, prev_d});
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                acc <= acc + 1;
                chk(exp_tx.size() != 0, "tx_extra", 64'(bus.o_tx_data), 64'd0);
                if (exp_tx.size() != 0) begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    chk(bus.o_tx_data == e, "tx_byte", 64'(bus.o_tx_data), 64'(e));
                end
            end
            if (bus.o_write_instruction_flag) begin
                chk(exp_wr.size() != 0, "wr_extra", 64'(bus.o_address_to_write_inst), 64'd0);
                if (exp_wr.size() != 0) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk(bus.o_address_to_write_inst == w.addr && bus.o_instruction_to_write == w.data,
                        "imem_write", {bus.o_address_to_write_inst, bus.o_instruction_to_write},
                        {w.addr, w.data});
                end
            end
            if (!halt) halt_lo <= halt_lo + 1;
        end
        prev_v <= bus.o_tx_valid && rst_n;
        prev_r <= bus.i_tx_ready;
        prev_d <= bus.o_tx_data;
    end

    initial begin
        int a0, h0;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        if_id  = 64'h1122_3344_5566_7788;
        id_ex  = {11'h7FF, 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4};
        ex_mem = {12'hABC, 64'hE1E2E3E4_F1F2F3F4};
        mem_wb = {7'h55, 64'h0F0E0D0C_0B0A0908};

        repeat (3) @(posedge clk);
        #1;
        chk(halt == 1'b1, "rst_halt", 64'(halt), 64'd1);
        chk(stall == 1'b0, "rst_stall", 64'(stall), 64'd0);
        chk(bus.o_tx_valid == 1'b0, "rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
        chk(bus.o_write_instruction_flag == 1'b0, "rst_wr_flag", 64'(bus.o_write_instruction_flag), 64'd0);
        chk(bus.o_address_to_write_inst == 0 && bus.o_instruction_to_write == 0, "rst_wr_bus",
            {bus.o_address_to_write_inst, bus.o_instruction_to_write}, 64'd0);
        chk(reg_read == 0 && mem_addr == 0, "rst_rd_addr", {27'(reg_read), mem_addr}, 64'd0);
        rst_n = 1'b1;

        // Load two words.
        exp_wr.push_back('{32'd0, 32'h2001_0005});
        exp_wr.push_back('{32'd4, 32'hFFFF_FFFF});
        send_byte(CMD_LOAD);
        chk(stall == 1'b1, "stall_in_load", 64'(stall), 64'd1);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        repeat (4) send_byte(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk(exp_wr.size() == 0, "load_writes_left", 64'(exp_wr.size()), 64'd0);
        chk(stall == 1'b0 && halt == 1'b1, "stall_after_load", {stall, halt}, 64'h1);
        chk(dut.state == IDLE, "load_idle", 64'(dut.state), 64'(IDLE));

        // Continuous run: program ends in the 20th running cycle.
        pe_arm = 1'b1;
        a0 = acc; h0 = halt_lo;
        push_frame(32'h14);
        send_byte(CMD_CONT);
        wait_frame(a0, h0, 20);

        // Second run after the end: no halt release.
        a0 = acc; h0 = halt_lo;
        push_frame(32'h14);
        send_byte(CMD_CONT);
        wait_frame(a0, h0, 0);

        // Reload (halt word only) clears the ended flag and counter.
        pe_arm = 1'b0;
        exp_wr.push_back('{32'd0, 32'hFFFF_FFFF});
        send_byte(CMD_LOAD);
        repeat (4) send_byte(8'hFF);
        repeat (3) @(posedge clk);
        chk(exp_wr.size() == 0, "reload_writes_left", 64'(exp_wr.size()), 64'd0);

        // Single step.
        a0 = acc; h0 = halt_lo;
        push_frame(32'd1);
        send_byte(CMD_STEP);
        wait_frame(a0, h0, 1);

        // Step under random backpressure.
        bp_en = 1'b1;
        a0 = acc; h0 = halt_lo;
        push_frame(32'd2);
        send_byte(CMD_STEP);
        wait_frame(a0, h0, 1);
        bp_en = 1'b0;
        @(posedge clk);

        // Reset after 10 bytes of a frame.
        a0 = acc;
        push_frame(32'd3);
        send_byte(CMD_STEP);
        for (int i = 0; i < 2000 && (acc - a0) < 10; i++) @(posedge clk);
        chk(acc - a0 >= 10, "reset_wait", 64'(acc - a0), 64'd10);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk(bus.o_tx_valid == 1'b0, "mid_rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
        chk(halt == 1'b1, "mid_rst_halt", 64'(halt), 64'd1);
        chk(dut.state == IDLE, "mid_rst_idle", 64'(dut.state), 64'(IDLE));
        rst_n = 1'b1;
        exp_tx.delete();

        // Fresh step after reset: full frame, counter restarted.
        a0 = acc; h0 = halt_lo;
        push_frame(32'd1);
        send_byte(CMD_STEP);
        wait_frame(a0, h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side controller that sits directly upstream of the pipeline top.
- Takes byte commands from a UART receiver and loads the program into instruction memory.
- Drives halt/stall to run the pipeline continuously or one cycle at a time.
- Serialises a state dump (pipeline latches, register bank, data memory) to a UART transmitter; reads that state through the pipeline's debug ports.

Parameters:
- IMEM_WORDS, 256: instruction-memory depth in words; load address wraps modulo IMEM_WORDS*4.
- MEM_DUMP_WORDS, 32: data-memory words included in each dump.
- HALT_INSTR, 32'hFFFF_FFFF: instruction word that terminates a load.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, byte valid
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  byte offered to TX
- i_tx_ready  in  1  TX accepts byte when valid&ready
- o_halt  out  1  freezes pipeline
- o_stall  out  1  stalls fetch/decode
- o_write_instruction_flag  out  1  instruction-memory write enable
- o_instruction_to_write  out  32  instruction word
- o_address_to_write_inst  out  32  byte address of the write
- i_IF_ID_latch  in  64  latch snapshot
- i_ID_EX_latch  in  139  latch snapshot
- i_EX_MEM_latch  in  76  latch snapshot
- i_MEM_WB_latch  in  71  latch snapshot
- o_reg_read  out  5  register index to read
- i_reg_content  in  32  register value, valid 1 cycle after index
- o_addr_to_read_mem  out  32  data-memory byte address
- i_mem_addr_content  in  32  memory word, valid 1 cycle after address
- i_program_end  in  1  pipeline reached end of program

Behaviour:
- Reset values (i_reset==0 at a clock edge): state IDLE, o_halt=1, o_stall=0, o_write_instruction_flag=0, o_tx_valid=0, all data/address outputs 0, load address 0, byte counter 0, ended flag 0.
- Commands are taken only in IDLE. Command bytes: 'L' 0x4C load, 'C' 0x43 continuous, 'S' 0x53 step. Any other byte is ignored. A byte received outside IDLE/LOAD_BYTES is dropped.
- LOAD_BYTES:
  - o_stall=1, o_halt=1.
  - Collect 4 bytes MSB-first into a word.
  - After the 4th byte go to LOAD_WRITE.
- LOAD_WRITE (one cycle):
  - o_write_instruction_flag=1, with the assembled word and current address.
  - Address advances by 4, wrapping to 0 after (IMEM_WORDS-1)*4.
  - If the word == HALT_INSTR: go to IDLE, clear ended flag, reset load address to 0. Otherwise return to LOAD_BYTES.
- RUN ('C'):
  - o_halt=0 until the cycle i_program_end is sampled high; o_halt returns to 1 on the next edge.
  - Set ended flag, then go to DUMP.
  - If the ended flag is already set, go straight to DUMP with o_halt held at 1.
- STEP ('S'):
  - o_halt=0 for exactly one cycle (skipped if ended), then DUMP.
  - Set ended flag if i_program_end is high in that cycle.
- DUMP frame, a sequence of 32-bit words each sent as 4 bytes MSB-first:
  - IF_ID: 2 words.
  - ID_EX: 5 words, zero-extended to 160 bits.
  - EX_MEM: 3 words, zero-extended to 96 bits.
  - MEM_WB: 3 words, zero-extended to 96 bits.
  - Registers 0..31: 32 words.
  - Memory addresses 0,4,...,4*(MEM_DUMP_WORDS-1).
- DUMP sub-states:
  - DUMP_ADDR: drive o_reg_read / o_addr_to_read_mem for word k.
  - DUMP_CAPTURE: register the source word.
  - DUMP_SEND: hold o_tx_valid with a stable byte until i_tx_ready; 4 handshakes per word.
  - After the last word, return to IDLE.
- Latches are sampled in DUMP_CAPTURE; o_halt=1 throughout DUMP, so they are static.
- Throughput: at most one byte per cycle. A word takes a minimum of 6 cycles.
- Reset mid-operation aborts any load, run or dump immediately. A partially sent frame is not resumed.

Optional Feature:
- DBG_CYCLE_COUNT_EN defined:
  - A 32-bit counter increments every cycle o_halt==0 and saturates at 32'hFFFF_FFFF.
  - It is cleared by reset and by completion of a load.
  - It is sent as an extra first word of every dump frame.
- Undefined: no counter, and the frame starts at IF_ID.

Decomposition:
- Package debug_unit_pkg holds:
  - state enum;
  - command byte constants;
  - frame section word counts and total frame length (function of MEM_DUMP_WORDS and the macro).
- One sub-module, dbg_word_serializer: a 32-bit word in with load strobe; 4 bytes out with valid/ready; busy/done status.

Test Plan:
- Load: send 'L', bytes 20 01 00 05, FF FF FF FF -> two write pulses: (addr 0, 0x20010005) then (addr 4, 0xFFFFFFFF); state back to IDLE; o_stall high only during the load.
- Step: after load, send 'S' -> o_halt low for exactly 1 cycle, then a frame of (45+32)*4=308 bytes. The first 8 bytes equal the IF_ID snapshot MSB-first.
- Continuous: send 'C' with a model asserting i_program_end after 20 cycles -> o_halt low for 20 cycles, then the frame. A second 'C' produces a frame with no halt release.
- Backpressure: i_tx_ready toggled randomly during a dump -> every byte held stable while unaccepted; no byte lost or duplicated.
- Reset mid-dump: assert i_reset after 10 bytes -> next cycle o_tx_valid=0, o_halt=1, state IDLE. A new 'S' yields a full frame.
- With DBG_CYCLE_COUNT_EN defined: 'C' running 20 cycles -> first dump word 0x00000014; frame is 312 bytes.
